// File: rtl/psum_accum_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM encoding,
// datapath width, default depth and the saturation ceiling.
package psum_accum_pkg;

    localparam int PSUM_W        = 32;
    localparam int DEFAULT_DEPTH = 64;

    localparam logic [PSUM_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/psum_accum_sat_add32.sv
// 33-bit unsigned add clamped to the 32-bit ceiling; sat flags a clamp.
module psum_accum_sat_add32
    import psum_accum_pkg::*;
(
    input  logic [PSUM_W-1:0] a,
    input  logic [PSUM_W-1:0] b,
    output logic [PSUM_W-1:0] sum,
    output logic              sat
);

    logic [PSUM_W:0] raw_sum;

    assign raw_sum = {1'b0, a} + {1'b0, b};
    assign sat     = raw_sum[PSUM_W];
    assign sum     = sat ? SAT_VAL : raw_sum[PSUM_W-1:0];

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: accumulates saturating sums per output neuron,
// then streams every entry out (clearing it) on a drain request.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum,
    input  logic [15:0]       psum_idx,
    output logic              psum_ready,
    input  logic              drain_start,
    output logic              out_valid,
    output logic [PSUM_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic              drain_done,
    output logic              err_oor,
    output logic              err_sat
);

    state_t state_reg, state_next;

    logic [PSUM_W-1:0] entry_reg [DEPTH];

    logic              s1_valid_reg;
    logic [IDX_W-1:0]  s1_idx_reg;
    logic [PSUM_W-1:0] s1_psum_reg;

    logic [IDX_W-1:0]  ptr_reg;
    logic              out_valid_reg;
    logic [PSUM_W-1:0] out_data_reg;
    logic              drain_done_reg;
    logic              err_oor_reg;
    logic              err_sat_reg;

    logic              xfer;
    logic              in_range;
    logic              out_hs;
    logic              ptr_last;
    logic [IDX_W-1:0]  ptr_inc;
    logic [PSUM_W-1:0] acc_sum;
    logic              acc_sat;
    logic [PSUM_W-1:0] first_data;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN is held for the drain_done cycle so psum_ready only rises after it.
    always_comb begin
        state_next = state_reg;
        psum_ready = 1'b0;
        case (state_reg)
            ST_ACCUM: begin
                psum_ready = !rst;
                if (drain_start) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done_reg) begin
                    state_next = ST_ACCUM;
                end
            end
            default: begin
                state_next = ST_ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate path
    // ------------------------------------------------------------------
    assign xfer     = psum_valid && psum_ready;
    assign in_range = psum_idx < 16'(DEPTH);

    psum_accum_sat_add32 u_sat_add (
        .a   (entry_reg[s1_idx_reg]),
        .b   (s1_psum_reg),
        .sum (acc_sum),
        .sat (acc_sat)
    );

    // ------------------------------------------------------------------
    // Drain path
    // ------------------------------------------------------------------
    assign out_hs   = out_valid_reg && out_ready;
    assign ptr_last = ptr_reg == IDX_W'(DEPTH - 1);
    assign ptr_inc  = ptr_reg + IDX_W'(1);

    // The update retiring on the FLUSH edge may target entry 0; forward it.
    assign first_data = (s1_valid_reg && (s1_idx_reg == '0)) ? acc_sum : entry_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            if (s1_valid_reg) begin
                entry_reg[s1_idx_reg] <= acc_sum;
            end
            if (state_reg == ST_DRAIN && out_hs) begin
                entry_reg[ptr_reg] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_idx_reg     <= '0;
            s1_psum_reg    <= '0;
            ptr_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            drain_done_reg <= 1'b0;
            err_oor_reg    <= 1'b0;
            err_sat_reg    <= 1'b0;
        end else begin
            // Out-of-range indices are consumed but never reach stage 1.
            s1_valid_reg <= xfer && in_range;
            if (xfer) begin
                s1_idx_reg  <= psum_idx[IDX_W-1:0];
                s1_psum_reg <= psum;
            end
            if (xfer && !in_range) begin
                err_oor_reg <= 1'b1;
            end
            if (s1_valid_reg && acc_sat) begin
                err_sat_reg <= 1'b1;
            end

            drain_done_reg <= 1'b0;
            if (state_reg == ST_FLUSH) begin
                out_valid_reg <= 1'b1;
                ptr_reg       <= '0;
                out_data_reg  <= first_data;
            end else if (state_reg == ST_DRAIN && out_hs) begin
                if (ptr_last) begin
                    out_valid_reg  <= 1'b0;
                    drain_done_reg <= 1'b1;
                end else begin
                    ptr_reg      <= ptr_inc;
                    out_data_reg <= entry_reg[ptr_inc];
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_idx    = ptr_reg;
    assign drain_done = drain_done_reg;
    assign err_oor    = err_oor_reg;
    assign err_sat    = err_sat_reg;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: accumulation, saturation, out-of-range,
// drain with stalls, drain racing a transfer and reset mid-drain.
module tb_psum_accum;

    localparam int DEPTH = 64;
    localparam int IDX_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        psum_valid;
    logic [31:0] psum;
    logic [15:0] psum_idx;
    logic        psum_ready;
    logic        drain_start;
    logic        out_valid;
    logic [31:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic        out_ready;
    logic        drain_done;
    logic        err_oor;
    logic        err_sat;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_mem [DEPTH];

    always #5 clk = ~clk;

    psum_accum #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .psum_valid  (psum_valid),
        .psum        (psum),
        .psum_idx    (psum_idx),
        .psum_ready  (psum_ready),
        .drain_start (drain_start),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_ready   (out_ready),
        .drain_done  (drain_done),
        .err_oor     (err_oor),
        .err_sat     (err_sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference saturating accumulate into the expected-value table.
    task automatic model_add(input int idx, input logic [31:0] val);
        logic [32:0] s;
        if (idx < DEPTH) begin
            s = {1'b0, exp_mem[idx]} + {1'b0, val};
            exp_mem[idx] = s[32] ? 32'hFFFF_FFFF : s[31:0];
        end
    endtask

    task automatic send(input int idx, input logic [31:0] val);
        psum_valid = 1'b1;
        psum_idx   = 16'(idx);
        psum       = val;
        chk("send_ready", {31'd0, psum_ready}, 32'd1);
        model_add(idx, val);
        $display("send idx=%0d psum=0x%08h", idx, val);
        tick();
        psum_valid = 1'b0;
    endtask

    // Full drain; stall_at = entry held for two stalled cycles,
    // with_xfer = transfer 1 to idx 63 alongside drain_start,
    // abort_at = entry at which rst is applied (-1 for none).
    task automatic drain(input int stall_at, input bit with_xfer, input int abort_at);
        int guard;
        drain_start = 1'b1;
        if (with_xfer) begin
            psum_valid = 1'b1;
            psum_idx   = 16'd63;
            psum       = 32'd1;
            chk("xfer_ready", {31'd0, psum_ready}, 32'd1);
            model_add(63, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        drain_start = 1'b0;
        psum_valid  = 1'b0;
        chk("flush_ready", {31'd0, psum_ready}, 32'd0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            guard = 0;
            while (!out_valid && guard < 8) begin
                tick();
                guard++;
            end
            chk($sformatf("out_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("out_idx[%0d]", i), {26'd0, out_idx}, 32'(i));
            chk($sformatf("out_data[%0d]", i), out_data, exp_mem[i]);
            if (i == abort_at) begin
                rst = 1'b1;
                tick();
                chk("abort_ready", {31'd0, psum_ready}, 32'd0);
                rst = 1'b0;
                chk("abort_valid", {31'd0, out_valid}, 32'd0);
                chk("abort_done", {31'd0, drain_done}, 32'd0);
                tick();
                chk("abort_accum", {31'd0, psum_ready}, 32'd1);
                chk("abort_done2", {31'd0, drain_done}, 32'd0);
                for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
                $display("drain aborted at entry %0d", i);
                return;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_idx", {26'd0, out_idx}, 32'(i));
                    chk("stall_data", out_data, exp_mem[i]);
                end
                out_ready = 1'b1;
            end
            if (i == 0) chk("drain_ready", {31'd0, psum_ready}, 32'd0);
            tick();
        end
        chk("last_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_done", {31'd0, drain_done}, 32'd1);
        chk("done_ready", {31'd0, psum_ready}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, drain_done}, 32'd0);
        chk("post_ready", {31'd0, psum_ready}, 32'd1);
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;
        $display("drain complete stall_at=%0d with_xfer=%0d", stall_at, with_xfer);
    endtask

    initial begin
        rst         = 1'b1;
        psum_valid  = 1'b0;
        psum        = '0;
        psum_idx    = '0;
        drain_start = 1'b0;
        out_ready   = 1'b0;
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = '0;

        tick();
        tick();
        chk("rst_ready", {31'd0, psum_ready}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, drain_done}, 32'd0);
        chk("rst_oor", {31'd0, err_oor}, 32'd0);
        chk("rst_sat", {31'd0, err_sat}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'd0, psum_ready}, 32'd1);

        // 3 + 4 at idx 5 on consecutive cycles
        send(5, 32'd3);
        send(5, 32'd4);
        chk("exp5", exp_mem[5], 32'd7);
        drain(-1, 1'b0, -1);

        // saturation at idx 2
        send(2, 32'hFFFF_FFF0);
        send(2, 32'h0000_0020);
        chk("sat_early", {31'd0, err_sat}, 32'd0);
        tick();
        chk("sat_flag", {31'd0, err_sat}, 32'd1);
        drain(-1, 1'b0, -1);
        chk("sat_sticky", {31'd0, err_sat}, 32'd1);

        // out-of-range indices (first beyond range is exactly DEPTH)
        chk("oor_clear", {31'd0, err_oor}, 32'd0);
        send(64, 32'd5);
        tick();
        chk("oor_64", {31'd0, err_oor}, 32'd1);
        send(70, 32'd9);
        drain(-1, 1'b0, -1);
        chk("oor_sticky", {31'd0, err_oor}, 32'd1);

        // transfer in the drain_start cycle
        drain(-1, 1'b1, -1);

        // stalled drain with several entries, then an empty drain
        send(0, 32'h11);
        send(7, 32'd1);
        send(7, 32'd2);
        send(7, 32'd4);
        send(10, 32'hA);
        send(63, 32'h55);
        drain(3, 1'b0, -1);
        drain(-1, 1'b0, -1);

        // reset at the 10th output, then drain reads zeros
        send(20, 32'd5);
        send(9, 32'd6);
        drain(-1, 1'b0, 9);
        chk("abort_oor", {31'd0, err_oor}, 32'd0);
        chk("abort_sat", {31'd0, err_sat}, 32'd0);
        drain(-1, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
